ram_arbiter: RTL
================

# ram_arbiter

Two-master arbiter for the data RAM. The core's load/store port and an external loader/debug port (the ext port) share the RAM's read and write ports. The arbiter grants at most one access per cycle. The core has fixed priority, and a starvation counter gives the ext port a guaranteed slot. The arbiter sits between `risc_v_pipe_top`/loader and `ram`, and drives the RAM's `rena/raddr/wena/waddr/wdata` ports directly.

## Interface
Parameters:
- `DW`, default 32: data width (matches `MEM`).
- `AW`, default 32: address width (matches `MEM_ADDR`).
- `STARVE_LIMIT`, default 8: number of consecutive denied ext cycles before the ext port is forced through. Must be ≥1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_100MHz`  in  1  system clock; all logic is on the rising edge.
  - `srst`  in  1  synchronous active-high reset.
- Core port:
  - `core_req_i`  in  1  core access request.
  - `core_we_i`  in  1  1 = write, 0 = read.
  - `core_addr_i`  in  AW  core address.
  - `core_wdata_i`  in  DW  core write data.
  - `core_gnt_o`  out  1  core request accepted this cycle.
  - `core_stall_o`  out  1  `core_req_i & ~core_gnt_o`; feeds the pipeline `hold`.
  - `core_rvalid_o`  out  1  core read data valid.
  - `core_rdata_o`  out  DW  core read data; 0 when `core_rvalid_o` is 0.
- Ext port:
  - `ext_req_i`, `ext_we_i`, `ext_addr_i`, `ext_wdata_i`, `ext_gnt_o`, `ext_rvalid_o`, `ext_rdata_o`: same meanings and widths as the core port.
- RAM port:
  - `ram_rena_o`  out  1  RAM read enable.
  - `ram_raddr_o`  out  AW  RAM read address.
  - `ram_wena_o`  out  1  RAM write enable.
  - `ram_waddr_o`  out  AW  RAM write address.
  - `ram_wdata_o`  out  DW  RAM write data.
  - `ram_rdata_i`  in  DW  RAM read data; valid one cycle after `ram_rena_o`.

## Operation
- Handshake:
  - A master holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt` high.
  - A request is accepted in the cycle where `req & gnt`.
  - A master may re-request in the following cycle.
- Grant logic is combinational from the requests and registered state. At most one `gnt` is high per cycle.
- State machine:
  - `ARB` (reset state):
    - Core wins whenever `core_req_i` is high.
    - Ext is granted only if `core_req_i` is low.
    - Go to `FORCE_EXT` when `starve_cnt == STARVE_LIMIT`.
  - `FORCE_EXT`:
    - Ext is granted unconditionally. Core is denied, so `core_stall_o` is high if the core is requesting.
    - Return to `ARB` next cycle.
    - If `ext_req_i` was withdrawn, grant nothing and return to `ARB`.
- Starvation counter `starve_cnt`:
  - Width is `$clog2(STARVE_LIMIT+1)`.
  - Increments when `ext_req_i & ~ext_gnt_o`.
  - Clears on an ext grant or when `ext_req_i` is low.
  - Saturates at `STARVE_LIMIT`.
- Issue stage (registered):
  - An accepted access drives exactly one of `ram_rena_o` or `ram_wena_o` for one cycle, with its address and data.
  - The stage also captures an owner tag and a read flag.
- Response stage:
  - The owner/read tag is delayed one more cycle.
  - `ram_rdata_i` is routed combinationally to the owner's `rdata`, with `rvalid` high for exactly one cycle.
  - The non-owner's `rdata` is 0.
  - Writes produce no `rvalid`.
- Idle cycles: the RAM enables are low. Address and data outputs hold their last values; they are don't-care.

## Timing
- Reset (`srst` sampled high):
  - State goes to `ARB` and `starve_cnt` to 0.
  - Issue and response tags are cleared.
  - `ram_rena_o`, `ram_wena_o`, `ram_raddr_o`, `ram_waddr_o` and `ram_wdata_o` are 0.
  - Both `rvalid_o` and `rdata_o` outputs are 0.
  - `gnt` and `stall` are forced to 0 while `srst` is high.
- Latency:
  - Grant in cycle N.
  - RAM command at N+1.
  - `rvalid`/`rdata` at N+2.
- Throughput: one access per cycle sustained. Back-to-back grants to either master, or alternating grants, are legal.
- Reset during an in-flight read: the access is dropped and no `rvalid` is produced after reset.
- Simultaneous requests in `ARB` with `starve_cnt < STARVE_LIMIT`: core wins, ext is stalled.
- Write followed by a read of the same address on consecutive grants: ordering is preserved. The RAM sees the write one cycle before the read.

## Structure
- Shared package/defines (`define.v`): `MEM`/`MEM_ADDR` widths, the state encoding (`ARB_S`, `FORCE_EXT_S`), and the owner encoding (`OWN_CORE = 0`, `OWN_EXT = 1`).
- One natural sub-module, `arb_starve_ctrl`: holds the state machine plus `starve_cnt`, and outputs `core_gnt`/`ext_gnt`.
- Issue and response pipeline registers stay in `ram_arbiter`.

## Test plan
- Reset: assert `srst` for 2 cycles with both requests high → all outputs 0. First grant goes to the core in the cycle after `srst` falls.
- Core read, address 0x10, RAM returns 0xDEADBEEF → `core_gnt` at N, `ram_rena_o=1` with `raddr=0x10` at N+1, `core_rvalid_o=1` with `core_rdata_o=0xDEADBEEF` at N+2. `ext_rdata_o=0`.
- Ext write 0x55AA to address 0x20 with core idle → `ram_wena_o=1`, `waddr=0x20`, `wdata=0x55AA` at N+1. No `rvalid` on either port.
- Starvation: core and ext both request continuously, `STARVE_LIMIT=8` → 8 core grants, then 1 ext grant with `core_stall_o=1` for that cycle, then the pattern repeats.
- Interleaved back-to-back reads, core/ext/core to addresses 0/4/8 → three consecutive `rena` cycles. `rvalid` is steered to the correct owner in order, with no bubbles.
- `srst` in the cycle after a read grant → no `rvalid` afterwards, `starve_cnt=0`, state `ARB`.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared widths, arbiter state encoding and owner tags for the data-RAM arbiter.
package ram_arbiter_pkg;
  localparam int MEM        = 32;
  localparam int MEM_ADDR   = 32;
  localparam int ARB_STAGES = 2;   // issue stage + response stage

  typedef enum logic {
    ARB_S       = 1'b0,
    FORCE_EXT_S = 1'b1
  } arb_state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_EXT  = 1'b1;
endpackage

// File: rtl/ram_arbiter_starve_ctrl.sv
// Fixed core priority with a starvation counter that forces one ext slot
// after STARVE_LIMIT consecutive denied ext cycles.
module arb_starve_ctrl
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic srst,
  input  logic core_req,
  input  logic ext_req,
  output logic core_gnt,
  output logic ext_gnt
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  arb_state_t    state;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (!srst) begin
      if (state == FORCE_EXT_S) begin
        ext_gnt = ext_req;
      end else begin
        core_gnt = core_req;
        ext_gnt  = ext_req & ~core_req;
      end
    end
  end

  always_comb begin
    cnt_nxt = '0;
    if (ext_req && !ext_gnt)
      cnt_nxt = (starve_cnt == LIMIT_C) ? starve_cnt : starve_cnt + 1'b1;
  end

  // Switch on the cycle the count reaches the limit so the forced slot lands
  // right after exactly STARVE_LIMIT denials.
  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= ARB_S;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= cnt_nxt;
      case (state)
        ARB_S:       if (cnt_nxt == LIMIT_C) state <= FORCE_EXT_S;
        FORCE_EXT_S: state <= ARB_S;
        default:     state <= ARB_S;
      endcase
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Two-master (core/ext) arbiter for the data RAM: grant at N, RAM command at
// N+1, read data steered to the owner at N+2.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DW           = MEM,
  parameter int AW           = MEM_ADDR,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk_100MHz,
  input  logic          srst,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic          core_gnt_o,
  output logic          core_stall_o,
  output logic          core_rvalid_o,
  output logic [DW-1:0] core_rdata_o,
  input  logic          ext_req_i,
  input  logic          ext_we_i,
  input  logic [AW-1:0] ext_addr_i,
  input  logic [DW-1:0] ext_wdata_i,
  output logic          ext_gnt_o,
  output logic          ext_rvalid_o,
  output logic [DW-1:0] ext_rdata_o,
  output logic          ram_rena_o,
  output logic [AW-1:0] ram_raddr_o,
  output logic          ram_wena_o,
  output logic [AW-1:0] ram_waddr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i
);
  localparam int STAGES = ARB_STAGES;

  logic          acc, sel_we, sel_own;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [STAGES:1] vld_pipe;   // read in flight: [1] issue, [2] response
  logic [STAGES:1] own_pipe;

  arb_starve_ctrl #(.STARVE_LIMIT(STARVE_LIMIT)) u_ctrl (
    .clk      (clk_100MHz),
    .srst     (srst),
    .core_req (core_req_i),
    .ext_req  (ext_req_i),
    .core_gnt (core_gnt_o),
    .ext_gnt  (ext_gnt_o)
  );

  assign core_stall_o = core_req_i & ~core_gnt_o & ~srst;

  assign acc       = core_gnt_o | ext_gnt_o;
  assign sel_own   = ext_gnt_o ? OWN_EXT : OWN_CORE;
  assign sel_we    = ext_gnt_o ? ext_we_i : core_we_i;
  assign sel_addr  = ext_gnt_o ? ext_addr_i : core_addr_i;
  assign sel_wdata = ext_gnt_o ? ext_wdata_i : core_wdata_i;

  always_ff @(posedge clk_100MHz) begin
    if (srst) begin
      vld_pipe    <= '0;
      own_pipe    <= '0;
      ram_wena_o  <= 1'b0;
      ram_raddr_o <= '0;
      ram_waddr_o <= '0;
      ram_wdata_o <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], acc & ~sel_we};
      own_pipe   <= {own_pipe[STAGES-1:1], sel_own};
      ram_wena_o <= acc & sel_we;
      if (acc && !sel_we) ram_raddr_o <= sel_addr;
      if (acc && sel_we) begin
        ram_waddr_o <= sel_addr;
        ram_wdata_o <= sel_wdata;
      end
    end
  end

  assign ram_rena_o = vld_pipe[1];

  assign core_rvalid_o = vld_pipe[STAGES] & (own_pipe[STAGES] == OWN_CORE);
  assign ext_rvalid_o  = vld_pipe[STAGES] & (own_pipe[STAGES] == OWN_EXT);
  assign core_rdata_o  = core_rvalid_o ? ram_rdata_i : '0;
  assign ext_rdata_o   = ext_rvalid_o  ? ram_rdata_i : '0;
endmodule
